// File: rtl/i_term_scan.sv
// Current-termination scanner: per channel, averages i*R/2^RSHIFT over 2^AVG_LOG2 samples,
// adds a common reference voltage, saturates to OW bits and hands the result out via valid/ready.
module i_term_scan #(
  parameter int NCH      = 4,
  parameter int IW       = 12,
  parameter int RW       = 8,
  parameter int OW       = 16,
  parameter int RSHIFT   = 4,
  parameter int AVG_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NCH*IW-1:0]     i_in,
  input  logic [NCH*RW-1:0]     res,
  input  logic signed [OW-1:0]  refnode,
  output logic signed [OW-1:0]  vout,
  output logic [3:0]            ch_id,
  output logic                  sat,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int PW = IW + RW + 1;
  localparam int AW = PW + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam int SW = ((OW > AW) ? OW : AW) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  localparam logic [CW-1:0] LAST_SAMPLE = CW'((1 << AVG_LOG2) - 1);
  localparam logic [3:0]    LAST_CH     = 4'(NCH - 1);

  localparam logic signed [SW-1:0] VMAX = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [SW-1:0] VMIN = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  logic [1:0]            state;
  logic [3:0]            idx;
  logic signed [AW-1:0]  acc;
  logic [CW-1:0]         cnt;

  logic [IW-1:0]         i_sel;
  logic [RW-1:0]         res_sel;
  logic signed [PW-1:0]  full;
  logic signed [PW-1:0]  prod;
  logic signed [AW-1:0]  acc_next;
  logic signed [AW-1:0]  avg;
  logic signed [SW-1:0]  sum;
  logic signed [OW-1:0]  vout_next;
  logic                  clip;

  // Select the active channel's current and resistance codes.
  always_comb begin
    i_sel   = '0;
    res_sel = '0;
    for (int k = 0; k < NCH; k++) begin
      if (idx == 4'(k)) begin
        i_sel   = i_in[k*IW +: IW];
        res_sel = res[k*RW +: RW];
      end else begin
        i_sel   = i_sel;
        res_sel = res_sel;
      end
    end
  end

  // Product, running sum including this cycle's sample, and the saturated output value.
  // The output is taken from acc_next so the final sample counts on the OUT-entry edge.
  always_comb begin
    full     = $signed(i_sel) * $signed({1'b0, res_sel});
    prod     = full >>> RSHIFT;
    acc_next = acc + AW'(prod);
    avg      = acc_next >>> AVG_LOG2;
    sum      = SW'(refnode) + SW'(avg);
    if (sum > VMAX) begin
      vout_next = {1'b0, {(OW-1){1'b1}}};
      clip      = 1'b1;
    end else if (sum < VMIN) begin
      vout_next = {1'b1, {(OW-1){1'b0}}};
      clip      = 1'b1;
    end else begin
      vout_next = sum[OW-1:0];
      clip      = 1'b0;
    end
  end

  // Frame sequencer: accumulate each channel, present it, advance on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= 4'd0;
      acc   <= '0;
      cnt   <= '0;
      vout  <= '0;
      ch_id <= 4'd0;
      sat   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_ACC;
            idx   <= 4'd0;
            acc   <= '0;
            cnt   <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ACC: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST_SAMPLE) begin
            state <= ST_OUT;
            vout  <= vout_next;
            sat   <= clip;
            ch_id <= idx;
          end else begin
            state <= ST_ACC;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            if (idx == LAST_CH) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end else begin
              state <= ST_ACC;
              idx   <= idx + 4'd1;
              acc   <= '0;
              cnt   <= '0;
            end
          end else begin
            state <= ST_OUT;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_valid = (state == ST_OUT);
  assign busy      = (state != ST_IDLE);

endmodule

// File: doc/i_term_scan.md
I_TERM_SCAN -- requirements
Module: i_term_scan

Interface
- Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter NCH, default 4, meaning number of current channels terminated and measured (1..16).
REQ-002 The block SHALL have parameter IW, default 12, meaning signed current-code width per channel.
REQ-003 The block SHALL have parameter RW, default 8, meaning unsigned termination-resistance code width per channel.
REQ-004 The block SHALL have parameter OW, default 16, meaning signed output voltage-code width.
REQ-005 The block SHALL have parameter RSHIFT, default 4, meaning arithmetic right shift applied to each current*resistance product.
REQ-006 The block SHALL have parameter AVG_LOG2, default 2, meaning log2 of samples averaged per channel (0..6).
- Ports (name, direction, width, meaning):
REQ-007 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-008 The block SHALL have port rst, input, 1, meaning synchronous, active-high reset.
REQ-009 The block SHALL have port start, input, 1, meaning request a measurement frame; accepted only in IDLE.
REQ-010 The block SHALL have port i_in, input, NCH*IW, meaning signed current codes; channel k at bits [k*IW +: IW].
REQ-011 The block SHALL have port res, input, NCH*RW, meaning unsigned termination resistance per channel, same packing.
REQ-012 The block SHALL have port refnode, input, OW, meaning signed reference voltage code, common to all channels.
REQ-013 The block SHALL have port vout, output, OW, meaning averaged terminated voltage for channel ch_id.
REQ-014 The block SHALL have port ch_id, output, 4, meaning channel index of vout.
REQ-015 The block SHALL have port sat, output, 1, meaning vout was clipped to the OW range.
REQ-016 The block SHALL have port out_valid, input or output as follows: output, 1, meaning vout/ch_id/sat hold a result.
REQ-017 The block SHALL have port out_ready, input, 1, meaning consumer accepts the result.
REQ-018 The block SHALL have port busy, output, 1, meaning high in any state other than IDLE.
REQ-019 The block SHALL have port done, output, 1, meaning one-cycle pulse after the last channel result is accepted.

Function
REQ-020 The FSM SHALL have states IDLE, ACC, OUT; IDLE -> ACC when start=1 in IDLE, with channel index=0, accumulator=0, sample count=0.
REQ-021 In ACC, on each cycle, the block SHALL sample channel index's i_in and res and compute prod = signed(i) * signed({1'b0,res}) >>> RSHIFT (arithmetic), then add it to a signed accumulator of width IW+RW+1+AVG_LOG2 with no overflow.
REQ-022 ACC SHALL last exactly 2^AVG_LOG2 cycles per channel, then go to OUT.
REQ-023 On entry to OUT, the block SHALL register vout = sat_OW(refnode + (acc >>> AVG_LOG2)), where the shift floors toward minus infinity and saturation clips to [-2^(OW-1), 2^(OW-1)-1]; it SHALL set sat=1 only when clipping occurred and set ch_id=channel index.
REQ-024 out_valid SHALL be 1 exactly while in OUT; vout, ch_id and sat SHALL be stable while out_valid=1 and out_ready=0.
REQ-025 A transfer SHALL occur when out_valid and out_ready are both 1; then, if the channel index is below NCH-1, the block SHALL increment the index, clear the accumulator and go to ACC, else it SHALL go to IDLE and pulse done for one cycle.
REQ-026 The first result SHALL be valid 2^AVG_LOG2+1 cycles after the start-accepted edge; with out_ready held 1, a frame SHALL take NCH*(2^AVG_LOG2+1) cycles.
REQ-027 start while busy=1 SHALL be ignored; start on the same cycle as done (in IDLE next cycle) SHALL be accepted only in IDLE.
REQ-028 Input changes mid-ACC SHALL be averaged as sampled; refnode SHALL be sampled on the OUT-entry edge only.
REQ-029 With AVG_LOG2=0, each channel SHALL use one sample, and the accumulator SHALL be the product itself.

Reset
REQ-030 While rst=1 at a clk edge, the block SHALL force the state to IDLE and clear the index, accumulator and sample count; it SHALL set vout=0, ch_id=0, sat=0, out_valid=0, busy=0 and done=0.
REQ-031 Reset asserted mid-ACC or mid-OUT SHALL abort the frame with no result or done pulse; start on the reset cycle SHALL be ignored.

Verification
REQ-032 Defaults: i_in all channels=160, res=8, refnode=100, start pulse, out_ready=1 -> vout=180 for ch_id 0..3, first out_valid at cycle 5, done at cycle 20.
REQ-033 Channel 2 with i=-160 and res=8 -> vout=20, sat=0; floor check: i=-1, res=1, AVG_LOG2=0 -> prod=-1, vout=refnode-1.
REQ-034 i=2047, res=255, refnode=32000 -> vout=32767, sat=1; i=-2048, res=255, refnode=-32000 -> vout=-32768, sat=1.
REQ-035 out_ready=0 for 7 cycles on ch 1 -> vout and ch_id held constant, out_valid=1 throughout, then ch 2 ACC begins the cycle after acceptance.
REQ-036 rst pulsed during ch 2 ACC, with start repeated during busy -> ignored; post-reset outputs are all 0, and a new start yields a full frame from ch 0.
REQ-037 Four samples on ch 0 with i=16, 32, 48, 64 and res=16 -> average 40, vout=refnode+40.
